// File: rtl/wash_pkg.sv
// wash_pkg: shared 7-segment codes, conversion FSM states and time constants
package wash_pkg;
    localparam int SEC_PER_MIN = 60;
    localparam int MAX_REMAIN  = 4095;
    localparam int SEC_W       = $clog2(MAX_REMAIN + 1);
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {IDLE, LOAD, DIV60, DIV10M, DIV10S, DONE} conv_state_e;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        unique case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/wash_sec_to_bcd.sv
// wash_sec_to_bcd: seconds to MM:SS BCD by repeated subtraction, one step per cycle
module wash_sec_to_bcd
    import wash_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEC_W-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       min_t,
    output logic [3:0]       min_o,
    output logic [3:0]       sec_t,
    output logic [3:0]       sec_o
);
    conv_state_e      state_q, state_d;
    logic [SEC_W-1:0] work_q, work_d;
    logic [6:0]       min_q, min_d;
    logic [2:0]       mt_q, mt_d, st_q, st_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        min_d   = min_q;
        mt_d    = mt_q;
        st_d    = st_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = start ? LOAD : IDLE;
                busy_d  = start;
                work_d  = start ? value : work_q;
            end
            LOAD: begin
                min_d   = '0;
                mt_d    = '0;
                st_d    = '0;
                state_d = DIV60;
            end
            DIV60: begin
                if (work_q >= SEC_W'(SEC_PER_MIN)) begin
                    work_d = work_q - SEC_W'(SEC_PER_MIN);
                    min_d  = min_q + 7'd1;
                end else state_d = DIV10M;
            end
            DIV10M: begin
                if (min_q >= 7'd10) begin
                    min_d = min_q - 7'd10;
                    mt_d  = mt_q + 3'd1;
                end else state_d = DIV10S;
            end
            DIV10S: begin
                if (work_q >= SEC_W'(10)) begin
                    work_d = work_q - SEC_W'(10);
                    st_d   = st_q + 3'd1;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = {1'b0, mt_q, min_q[3:0], 1'b0, st_q, work_q[3:0]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            min_q   <= '0;
            mt_q    <= '0;
            st_q    <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            min_q   <= min_d;
            mt_q    <= mt_d;
            st_q    <= st_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign {min_t, min_o, sec_t, sec_o} = bcd_q;
endmodule

// File: rtl/wash_time_display.sv
// wash_time_display: MM:SS multiplexed active-low 7-segment display with alarm blink
module wash_time_display
    import wash_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] remain_sec,
    input  logic        remain_vld,
    input  logic        alarm,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    logic             start, store, conv_busy, conv_done, scan_wrap, blink_wrap;
    logic [3:0]       min_t, min_o, sec_t, sec_o, dig;
    logic [6:0]       code;
    logic [SEC_W-1:0] value;
    logic             pend_q, pend_d, hide_q, hide_d, alarm_q;
    logic [11:0]      pend_val_q, pend_val_d;
    logic [SW-1:0]    scan_q, scan_d;
    logic [1:0]       idx_q, idx_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;

    // A strobe goes straight to the converter only when it is idle with nothing queued
    assign start = !conv_busy && (pend_q || (remain_vld && !conv_done));
    assign store = remain_vld && !(start && !pend_q);
    assign value = pend_q ? pend_val_q : remain_sec;

    wash_sec_to_bcd u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .min_t (min_t),
        .min_o (min_o),
        .sec_t (sec_t),
        .sec_o (sec_o)
    );

    always_comb begin
        pend_d     = store || (pend_q && !start);
        pend_val_d = store ? remain_sec : pend_val_q;
        scan_wrap  = scan_q == SW'(SCAN_DIV - 1);
        scan_d     = scan_wrap ? '0 : scan_q + SW'(1);
        idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
        blink_wrap = blink_q == BW'(BLINK_DIV - 1);
        blink_d    = (!alarm || !alarm_q || blink_wrap) ? '0 : blink_q + BW'(1);
        hide_d     = alarm && alarm_q && (hide_q ^ blink_wrap);
        dig        = idx_q == 2'd0 ? sec_o : idx_q == 2'd1 ? sec_t : idx_q == 2'd2 ? min_o : min_t;
        code       = (idx_q == 2'd3 && min_t == 4'd0) ? SEG_BLANK : seg_code(dig);
        seg_d      = hide_d ? 8'hFF : {idx_q != 2'd2, code};
        an_d       = hide_d ? 4'hF : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            blink_q    <= '0;
            hide_q     <= 1'b0;
            alarm_q    <= 1'b0;
            seg_q      <= 8'hFF;
            an_q       <= 4'hF;
        end else begin
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            blink_q    <= blink_d;
            hide_q     <= hide_d;
            alarm_q    <= alarm;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = conv_busy;
endmodule
